wave_channel_gen2: RTL
======================

Name: wave_channel_gen2

Overview:
- Parametrised successor to the fixed triangle channel.
- A single phase-accumulator voice clocked by clk50mhz. It selects triangle, pulse (4 duties), sawtooth or LFSR noise per note.
- Portamento, vibrato and length control are built in and are stepped by a one-cycle tempo strobe instead of a separate note clock.
- Sits between the sequencer (note/trigger/tick) and the mixer (wave_out).

Parameters:
- OUT_W, 4, sample width of wave_out (2..8).
- NOTE_W, 6, note number width (1..6). Note 0 = C2 (65.406 Hz), one semitone per step.
- PHASE_W, 24, phase accumulator width (16..32).
- LEN_W, 3, note_length width.

Ports:
- clk50mhz  in  1  50 MHz system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- note_in  in  NOTE_W  target note number.
- note_trig  in  1  one-cycle strobe: start a note.
- note_tick  in  1  one-cycle tempo strobe; all effect/length timing counts these.
- note_length  in  LEN_W  0 = sustain until next trigger; N = note lasts 4*N ticks.
- mode  in  2  0 triangle, 1 pulse, 2 sawtooth, 3 noise.
- duty  in  2  pulse duty: 0 12.5%, 1 25%, 2 50%, 3 75%.
- fx_sel  in  2  0 none, 1 portamento, 2 vibrato, 3 none (reserved).
- fx_optA  in  2  effect rate: step every fx_optA+1 ticks.
- fx_optB  in  2  vibrato depth: fx_optB+1 semitones.
- wave_out  out  OUT_W  registered sample, unsigned.
- active  out  1  note currently sounding.

Behaviour:
- Reset (synchronous, active-high, overrides everything including note_trig):
  - phase, cur_note, vib state, rate counter and length counter clear to 0.
  - LFSR = all ones (15'h7FFF).
  - active = 0, wave_out = 0.
  - This also applies mid-note.
- Pitch:
  - eff_note = clamp(cur_note + vib_off, 0, 2^NOTE_W-1).
  - inc = ROM[eff_note] = round(2^PHASE_W * 65.406 * 2^(n/12) / 50e6); ROM covers 0..63.
  - phase <= phase + inc every cycle while active, wrapping mod 2^PHASE_W. Wrap = carry out.
- Trigger (note_trig=1, not in reset):
  - phase <= 0; LFSR <= all ones.
  - Length counter <= 4*note_length; rate counter <= 0; vib step <= 0.
  - active <= 1.
  - cur_note <= note_in, except when fx_sel=1 and active=1: cur_note is kept and the target is latched from note_in.
  - A note_tick in the same cycle is ignored.
- Tick processing (note_tick=1, no trigger):
  - Rate counter increments. When it equals fx_optA it resets to 0 and an effect step occurs.
  - Portamento step: cur_note moves 1 toward the target; it stops when equal, no overshoot.
  - Vibrato step: vib_off cycles 0, +D, 0, -D, repeat, with D = fx_optB+1. vib_off = 0 whenever fx_sel != 2.
  - Length: if the counter is non-zero, it decrements; on the transition 1 -> 0, active <= 0 that cycle. A counter loaded with 0 never expires.
- Inactive: phase frozen, wave_out = 0 on the next cycle, effect and tick state held.
- Waveform (combinational from current phase/LFSR, then registered; 1 cycle latency to wave_out):
  - p = phase[PHASE_W-1 -: OUT_W+1].
  - Triangle: p MSB 0 -> p[OUT_W-1:0], else ~p[OUT_W-1:0]. Gives 0 up to max, then back down.
  - Pulse: all ones if phase top 3 bits < {1,2,4,6}[duty], else 0.
  - Saw: phase[PHASE_W-1 -: OUT_W].
  - Noise: LFSR taps x^15 + x^14 + 1, shifts once per phase wrap; output = {OUT_W{~lfsr[0]}}.
- Mode, duty and fx changes take effect immediately, with no retrigger. If fx_sel leaves 1, cur_note snaps to the latched target on the next cycle.

Test Plan:
- Reset, then trig note 57, mode 0, length 0:
  - inc = 591; active = 1 one cycle after trig.
  - wave_out rises 0 -> 15 -> 0 with period 2^24/591 ≈ 28388 cycles.
  - Assert rst mid-note -> wave_out = 0 and active = 0 on the next cycle.
- Trig note 0 vs note 12 (mode 2) -> inc 22 vs 44; saw period ratio exactly 2:1. Note 63 clamps the vibrato offset without wrapping.
- Mode 1, duty 0..3 over one period -> high fraction 1/8, 2/8, 4/8, 6/8 of cycles (±1 cycle).
- fx_sel=1, fx_optA=1: trig note 10, then trig note 14 -> cur_note 11, 12, 13, 14 on every 2nd tick, then holds. Retrigger with note 8 -> descends.
- fx_sel=2, fx_optA=0, fx_optB=1, note 20 -> eff_note 20, 22, 20, 18, 20 on successive ticks.
- note_length=2: active falls exactly on the 8th tick after trig, and wave_out = 0 the cycle after. Trig+tick coincident -> tick not counted. Mode 3 output reproduces the LFSR sequence from 7FFF.

Source files
------------

// File: rtl/wave_channel_gen2.sv
// -----------------------------------------------------------------------------
// wave_channel_gen2
//   One phase-accumulator voice. Per note it produces a triangle, a pulse with
//   four duties, a sawtooth or LFSR noise. Portamento, vibrato and note length
//   are built in. They advance on the one-cycle tempo strobe note_tick.
//   The voice sits between the sequencer (note/trigger/tick) and the mixer.
//
// Ports
//   clk50mhz     in   50 MHz system clock, rising edge
//   rst          in   synchronous active-high reset, overrides everything
//   note_in      in   [NOTE_W]  target note number (0 = C2, semitone steps)
//   note_trig    in   one-cycle strobe that starts a note
//   note_tick    in   one-cycle tempo strobe for effect and length timing
//   note_length  in   [LEN_W]   0 = sustain, N = note lasts 4*N ticks
//   mode         in   [2]  0 triangle, 1 pulse, 2 sawtooth, 3 noise
//   duty         in   [2]  pulse duty 12.5 / 25 / 50 / 75 %
//   fx_sel       in   [2]  0 none, 1 portamento, 2 vibrato, 3 none
//   fx_optA      in   [2]  effect step every fx_optA+1 ticks
//   fx_optB      in   [2]  vibrato depth fx_optB+1 semitones
//   wave_out     out  [OUT_W]  registered unsigned sample
//   active       out  note currently sounding
// -----------------------------------------------------------------------------
module wave_channel_gen2 #(
  parameter int OUT_W   = 4,
  parameter int NOTE_W  = 6,
  parameter int PHASE_W = 24,
  parameter int LEN_W   = 3
) (
  input  logic              clk50mhz,
  input  logic              rst,
  input  logic [NOTE_W-1:0] note_in,
  input  logic              note_trig,
  input  logic              note_tick,
  input  logic [LEN_W-1:0]  note_length,
  input  logic [1:0]        mode,
  input  logic [1:0]        duty,
  input  logic [1:0]        fx_sel,
  input  logic [1:0]        fx_optA,
  input  logic [1:0]        fx_optB,
  output logic [OUT_W-1:0]  wave_out,
  output logic              active
);

  localparam int ROM_N = 1 << NOTE_W;

  // Phase increment for note n. The table holds one octave (C2..B2) scaled by
  // 2^40 / 50e6. Higher octaves are left shifts of that table. The result is
  // rounded to the PHASE_W scale. This matches
  // round(2^PHASE_W * 65.406 * 2^(n/12) / 50e6) for every PHASE_W in 16..32.
  function automatic logic [PHASE_W-1:0] inc_calc(input int n);
    logic [63:0] base;
    logic [63:0] scaled;
    int          shift;
    case (n % 12)
      0:       base = 64'd1438293;
      1:       base = 64'd1523819;
      2:       base = 64'd1614429;
      3:       base = 64'd1710428;
      4:       base = 64'd1812136;
      5:       base = 64'd1919891;
      6:       base = 64'd2034054;
      7:       base = 64'd2155005;
      8:       base = 64'd2283148;
      9:       base = 64'd2418911;
      10:      base = 64'd2562747;
      default: base = 64'd2715136;
    endcase
    shift  = 40 - PHASE_W;
    scaled = (base << (n / 12)) + (64'd1 << (shift - 1));
    return PHASE_W'(scaled >> shift);
  endfunction

  // NOTE: the increment table is a constant ROM built from wires. It carries
  // no state, so it has no reset.
  logic [PHASE_W-1:0] w_rom [ROM_N];
  for (genvar g = 0; g < ROM_N; g++) begin : g_rom
    assign w_rom[g] = inc_calc(g);
  end

  // State
  logic [PHASE_W-1:0] r_phase;
  logic [NOTE_W-1:0]  r_cur_note;
  logic [NOTE_W-1:0]  r_target;
  logic [1:0]         r_vib_step;
  logic [1:0]         r_rate_cnt;
  logic [LEN_W+1:0]   r_len_cnt;
  logic [14:0]        r_lfsr;
  logic               r_active;
  logic [OUT_W-1:0]   r_wave;

  // Pitch path
  logic [2:0]          w_depth;
  logic signed [3:0]   w_vib_off;
  logic [NOTE_W+2:0]   w_eff_sum;
  logic [NOTE_W-1:0]   w_eff_note;
  logic [PHASE_W-1:0]  w_inc;
  logic [PHASE_W:0]    w_phase_sum;
  logic                w_wrap;

  // Waveform path
  logic [OUT_W:0]      w_p;
  logic [2:0]          w_top3;
  logic [2:0]          w_thr;
  logic [OUT_W-1:0]    w_wave;

  assign w_depth = {1'b0, fx_optB} + 3'd1;

  // NOTE: every signal assigned in an always_comb block gets a default first.
  // A path that leaves one unassigned would infer a latch.
  always_comb begin
    w_vib_off = '0;
    if (fx_sel == 2'd2) begin
      case (r_vib_step)
        2'd1:    w_vib_off = $signed({1'b0, w_depth});
        2'd3:    w_vib_off = -$signed({1'b0, w_depth});
        default: w_vib_off = '0;
      endcase
    end
  end

  // Signed sum with two guard bits. A negative sum clamps to 0. An overflow
  // clamps to the top note, so the pitch never wraps around.
  always_comb begin
    w_eff_sum  = (NOTE_W+3)'(r_cur_note) + (NOTE_W+3)'(w_vib_off);
    w_eff_note = w_eff_sum[NOTE_W-1:0];
    if (w_eff_sum[NOTE_W+2])
      w_eff_note = '0;
    else if (w_eff_sum[NOTE_W+1:NOTE_W] != 2'b00)
      w_eff_note = '1;
  end

  assign w_inc       = w_rom[w_eff_note];
  assign w_phase_sum = {1'b0, r_phase} + {1'b0, w_inc};
  assign w_wrap      = w_phase_sum[PHASE_W];

  assign w_p    = r_phase[PHASE_W-1 -: OUT_W+1];
  assign w_top3 = r_phase[PHASE_W-1 -: 3];

  always_comb begin
    case (duty)
      2'd0:    w_thr = 3'd1;
      2'd1:    w_thr = 3'd2;
      2'd2:    w_thr = 3'd4;
      default: w_thr = 3'd6;
    endcase
  end

  always_comb begin
    w_wave = '0;
    case (mode)
      2'd0:    w_wave = w_p[OUT_W] ? ~w_p[OUT_W-1:0] : w_p[OUT_W-1:0];
      2'd1:    w_wave = (w_top3 < w_thr) ? '1 : '0;
      2'd2:    w_wave = r_phase[PHASE_W-1 -: OUT_W];
      default: w_wave = {OUT_W{~r_lfsr[0]}};
    endcase
  end

  // NOTE: all state updates use non-blocking assignments. Every register then
  // sees the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk50mhz) begin
    if (rst) begin
      r_phase    <= '0;
      r_cur_note <= '0;
      r_target   <= '0;
      r_vib_step <= '0;
      r_rate_cnt <= '0;
      r_len_cnt  <= '0;
      r_lfsr     <= 15'h7FFF;
      r_active   <= 1'b0;
      r_wave     <= '0;
    end else begin
      // Outside portamento the sounding note follows the latched target. When
      // fx_sel leaves portamento mid-glide, the note snaps to the target.
      if (fx_sel != 2'd1)
        r_cur_note <= r_target;

      if (note_trig) begin
        r_phase    <= '0;
        r_lfsr     <= 15'h7FFF;
        r_len_cnt  <= {note_length, 2'b00};
        r_rate_cnt <= '0;
        r_vib_step <= '0;
        r_active   <= 1'b1;
        r_target   <= note_in;
        // A sounding note under portamento glides to the new target instead
        // of jumping to it.
        if (!(fx_sel == 2'd1 && r_active))
          r_cur_note <= note_in;
      end else if (r_active) begin
        r_phase <= w_phase_sum[PHASE_W-1:0];
        if (w_wrap)
          r_lfsr <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};

        if (note_tick) begin
          if (r_rate_cnt == fx_optA) begin
            r_rate_cnt <= '0;
            if (fx_sel == 2'd1) begin
              if (r_cur_note < r_target)
                r_cur_note <= r_cur_note + NOTE_W'(1);
              else if (r_cur_note > r_target)
                r_cur_note <= r_cur_note - NOTE_W'(1);
            end
            if (fx_sel == 2'd2)
              r_vib_step <= r_vib_step + 2'd1;
          end else begin
            r_rate_cnt <= r_rate_cnt + 2'd1;
          end

          // A counter loaded with 0 stays at 0, so the note sustains.
          if (r_len_cnt != '0) begin
            r_len_cnt <= r_len_cnt - (LEN_W+2)'(1);
            if (r_len_cnt == (LEN_W+2)'(1))
              r_active <= 1'b0;
          end
        end
      end

      r_wave <= r_active ? w_wave : '0;
    end
  end

  assign wave_out = r_wave;
  assign active   = r_active;

endmodule
